// File: rtl/accumulate_lanes.sv
// Multi-term accumulator with a SIMD lane split (1x32 / 2x16 / 4x8), per-lane
// wrap or unsigned saturation, sticky per-lane overflow and a term counter.
module accumulate_lanes #(
  parameter int unsigned MAC_MIN_WIDTH = 8,
  parameter int unsigned MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     init_load,
  input  logic [1:0]               cfg,
  input  logic                     sat_en,
  input  logic [CNT_WIDTH-1:0]     len,
  input  logic [MAC_ACC_WIDTH-1:0] init,
  input  logic [MAC_ACC_WIDTH-1:0] acc_in,
  input  logic                     in_valid,
  input  logic                     carry_in,
  output logic                     in_ready,
  output logic [MAC_ACC_WIDTH-1:0] out,
  output logic                     out_valid,
  output logic                     carry_out,
  output logic [3:0]               overflow,
  output logic                     busy
);

  localparam int unsigned GW  = MAC_MIN_WIDTH;
  localparam int unsigned GW1 = MAC_MIN_WIDTH + 1;
  localparam int unsigned NG  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]     len_q, len_d;
  logic [1:0]               cfg_q, cfg_d;
  logic                     sat_q, sat_d;
  logic [MAC_ACC_WIDTH-1:0] out_q, out_d;
  logic [3:0]               ovf_q, ovf_d;
  logic                     cout_q, cout_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;

  // Lane index owning granule g under a given lane mode (11 behaves as 1x32).
  function automatic logic [1:0] lane_of(input logic [1:0] mode, input int g);
    case (mode)
      2'b01:   return 2'(g / 2);
      2'b10:   return 2'(g);
      default: return 2'd0;
    endcase
  endfunction

  logic [GW-1:0]            gsum [NG];
  logic [3:0]               lane_start;
  logic [3:0]               lane_top;
  logic [3:0]               lane_cy;
  logic                     chain;
  logic                     top_cy;
  logic [GW:0]              wide;
  logic [MAC_ACC_WIDTH-1:0] sum_v;

  // Granule-wise ripple add; the chain is cut at every lane start so no carry
  // leaks between lanes, and carry_in only ever enters granule 0.
  always_comb begin
    lane_start = 4'b0001;
    lane_top   = 4'b1000;
    lane_cy    = 4'b0000;
    chain      = 1'b0;
    top_cy     = 1'b0;
    wide       = '0;
    sum_v      = '0;
    for (int g = 0; g < NG; g++) gsum[g] = '0;

    case (cfg_q)
      2'b01: begin
        lane_start = 4'b0101;
        lane_top   = 4'b1010;
      end
      2'b10: begin
        lane_start = 4'b1111;
        lane_top   = 4'b1111;
      end
      default: ;
    endcase

    for (int g = 0; g < NG; g++) begin
      if (lane_start[g]) chain = (g == 0) ? carry_in : 1'b0;
      wide    = {1'b0, out_q[g*GW +: GW]} + {1'b0, acc_in[g*GW +: GW]} + GW1'(chain);
      gsum[g] = wide[GW-1:0];
      chain   = wide[GW];
      if (lane_top[g] && chain) lane_cy[lane_of(cfg_q, g)] = 1'b1;
    end
    top_cy = chain;

    for (int g = 0; g < NG; g++) begin
      if (sat_q && lane_cy[lane_of(cfg_q, g)]) sum_v[g*GW +: GW] = '1;
      else                                     sum_v[g*GW +: GW] = gsum[g];
    end
  end

  logic accept;
  logic last_term;

  assign accept    = (state_q == S_ACC) && en && in_valid;
  assign last_term = (cnt_q == len_q - CNT_WIDTH'(1));

  // Next-state and next-output logic; init_load overrides everything else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    cfg_d   = cfg_q;
    sat_d   = sat_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    cout_d  = cout_q;

    if (init_load) begin
      out_d   = init;
      cnt_d   = '0;
      ovf_d   = 4'b0000;
      cout_d  = 1'b0;
      cfg_d   = cfg;
      sat_d   = sat_en;
      len_d   = len;
      state_d = (len != '0) ? S_ACC : S_DONE;
    end else begin
      case (state_q)
        S_ACC: begin
          if (accept) begin
            out_d  = sum_v;
            ovf_d  = ovf_q | lane_cy;
            cout_d = top_cy;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            if (last_term) state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_ACC);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      cfg_q       <= 2'b00;
      sat_q       <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 4'b0000;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      cfg_q       <= cfg_d;
      sat_q       <= sat_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign out       = out_q;
  assign overflow  = ovf_q;
  assign carry_out = cout_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule

// File: doc/accumulate_lanes.md
ACCUMULATE_LANES -- requirements
Module: accumulate_lanes

Interface
REQ-001 SHALL have parameter MAC_MIN_WIDTH, default 8, lane granule width in bits.
REQ-002 SHALL have parameter MAC_ACC_WIDTH, default 4*MAC_MIN_WIDTH, accumulator width; always equal to 4*MAC_MIN_WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, term-counter width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high. Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  global enable; when 0, no state changes except init_load.
- init_load  in  1  start pulse: load init, capture cfg/sat_en/len.
- cfg  in  2  lane mode: 00 = 1x32, 01 = 2x16, 10 = 4x8, 11 treated as 00.
- sat_en  in  1  1 = unsigned saturate per lane, 0 = wrap.
- len  in  CNT_WIDTH  number of terms to accumulate.
- init  in  MAC_ACC_WIDTH  initial accumulator value.
- acc_in  in  MAC_ACC_WIDTH  addend, split per lane like the accumulator.
- in_valid  in  1  addend valid.
- carry_in  in  1  added into lane 0 LSB on every accepted term.
- in_ready  out  1  high in ACC state.
- out  out  MAC_ACC_WIDTH  accumulator register.
- out_valid  out  1  one-cycle pulse: result complete.
- carry_out  out  1  registered carry out of the top lane from the last accepted add.
- overflow  out  4  sticky per-lane overflow; bit k = lane k; unused bits 0.
- busy  out  1  high in ACC or DONE.

Function
REQ-005 SHALL implement states IDLE, ACC, DONE.
REQ-006 On init_load (any state, en ignored), SHALL load out<=init, clear the term counter, overflow and carry_out, capture cfg/sat_en/len into shadow registers, and go to ACC if len!=0, else DONE.
REQ-007 init_load SHALL take priority over any same-cycle term acceptance; the coincident term is dropped.
REQ-008 A term SHALL be accepted in ACC when en & in_valid & in_ready; on no acceptance, the state is held.
REQ-009 On acceptance, each lane SHALL add its slice of acc_in; lane 0 also adds carry_in; the counter increments.
REQ-010 Lanes SHALL be MAC_ACC_WIDTH, /2 or /4 bits wide per captured cfg; no carry propagates across lane boundaries.
REQ-011 Lane carry-out with sat_en=0 SHALL wrap (mod 2^lane width) and set that lane's overflow bit.
REQ-012 Lane carry-out with sat_en=1 SHALL set that lane to all-ones and set its overflow bit.
REQ-013 carry_out SHALL take the top lane's raw carry on each accepted term, before saturation.
REQ-014 When the accepted term is number len (counter==len-1), SHALL go to DONE next cycle.
REQ-015 DONE SHALL last exactly one cycle with out_valid=1, then return to IDLE regardless of en.
REQ-016 In IDLE and DONE, in_ready=0 and out holds its value.
REQ-017 cfg, sat_en and len changes outside init_load SHALL have no effect on an in-progress operation.
REQ-018 Latency SHALL be one cycle from accepted term to updated out; one extra cycle from the last term to out_valid.

Reset
REQ-019 On rst (asynchronous, any time, including mid-ACC), SHALL clear state to IDLE and set out=0, out_valid=0, carry_out=0, overflow=0, busy=0, in_ready=0, counter=0, shadow cfg=00.
REQ-020 After rst deasserts, SHALL ignore terms until the next init_load.

Verification
REQ-021 Reset asserted mid-ACC, asynchronously between edges -> all outputs read 0 immediately, state IDLE.
REQ-022 cfg=00, init=0x0000_0010, len=3, acc_in=0x1 for 3 terms, carry_in=0 -> out=0x13, then out_valid pulses once, overflow=0.
REQ-023 cfg=10, sat_en=0, init=0xFF01_80FE, one term acc_in=0x0101_8003 -> out=0x0002_0001, overflow=4'b1011, carry_out=1.
REQ-024 cfg=01, sat_en=1, init=0xFFF0_0001, one term acc_in=0x0020_0001 -> out=0xFFFF_0002, overflow=4'b0010.
REQ-025 len=4, in_valid toggled with en low for 2 cycles and init_load re-issued on term 2 -> dropped terms not summed, restart from new init, out_valid only after 4 new terms.
REQ-026 len=0 init_load -> DONE next cycle, out=init, out_valid one cycle, in_ready never high.
